// File: rtl/fp_pkg.sv
// FP16 field constants, canonical encodings and the drain FSM state type
// shared by the accumulator/drain block.
package fp_pkg;
  localparam int EXP_MSB = 14;
  localparam int EXP_LSB = 10;
  localparam int MAN_W   = 10;
  localparam logic [4:0]  EXP_ALL1  = 5'h1F;
  localparam logic [15:0] FP16_QNAN = 16'h7FFF;
  localparam logic [15:0] FP16_PINF = 16'h7C00;
  localparam logic [15:0] FP16_ZERO = 16'h0000;

  typedef enum logic [1:0] {IDLE, HI, LO} drain_state_t;

  function automatic logic fp16_is_nan(input logic [15:0] v);
    return (v[EXP_MSB:EXP_LSB] == EXP_ALL1) && (v[MAN_W-1:0] != '0);
  endfunction

  function automatic logic fp16_is_inf(input logic [15:0] v);
    return (v[EXP_MSB:EXP_LSB] == EXP_ALL1) && (v[MAN_W-1:0] == '0);
  endfunction
endpackage

// File: rtl/fma_accum_drain_if.sv
// Result/accumulator/drain signal bundle between the FMA pipe tail and this block.
interface fma_accum_drain_if #(parameter int COUNT_W = 8);
  logic [15:0]        s_in;
  logic               s_save;
  logic               clear;
  logic [15:0]        acc_out;
  logic               drain_req;
  logic [7:0]         byte_out;
  logic               byte_valid;
  logic               byte_ready;
  logic               busy;
  logic               nan_seen;
  logic               inf_seen;
  logic [COUNT_W-1:0] count;

  modport master (
    output s_in, s_save, clear, drain_req, byte_ready,
    input  acc_out, byte_out, byte_valid, busy, nan_seen, inf_seen, count
  );
  modport slave (
    input  s_in, s_save, clear, drain_req, byte_ready,
    output acc_out, byte_out, byte_valid, busy, nan_seen, inf_seen, count
  );
endinterface

// File: rtl/fma_drain_ser.sv
// Snapshot register plus two-byte (high then low) valid/ready serializer.
module fma_drain_ser
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] load_data,
  output logic [7:0]  byte_out,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic        busy
);
  drain_state_t state, state_nxt;
  logic [15:0]  snap;
  logic [7:0]   byte_nxt;

  assign busy = (state != IDLE);

  // Byte register is loaded from the next state so byte_out lines up with byte_valid.
  always_comb begin
    state_nxt = state;
    byte_nxt  = byte_out;
    unique case (state)
      IDLE: if (load) begin
        state_nxt = HI;
        byte_nxt  = load_data[15:8];
      end
      HI: if (byte_ready) begin
        state_nxt = LO;
        byte_nxt  = snap[7:0];
      end
      LO: if (byte_ready) begin
        state_nxt = IDLE;
        byte_nxt  = 8'h00;
      end
      default: begin
        state_nxt = IDLE;
        byte_nxt  = 8'h00;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      snap       <= '0;
      byte_out   <= '0;
      byte_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      byte_out   <= byte_nxt;
      byte_valid <= (state_nxt != IDLE);
      if (state == IDLE && load) snap <= load_data;
    end
  end
endmodule

// File: rtl/fma_accum_drain.sv
// fp16 running accumulator with NaN/Inf tracking, saturating result count
// and a snapshot drain over a narrow byte port.
module fma_accum_drain
  import fp_pkg::*;
#(
  parameter logic [15:0] ACC_INIT     = FP16_ZERO,
  parameter int          COUNT_W      = 8,
  parameter bit          DRAIN_CLEARS = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  fma_accum_drain_if.slave bus
);
  logic [15:0]        acc;
  logic [COUNT_W-1:0] count;
  logic               nan_seen, inf_seen;
  logic               accept, load, busy;
  logic [15:0]        load_data;

  assign accept = bus.s_save && !bus.clear;
  assign load   = bus.drain_req && !busy;
  // A result arriving with the request is the value the requester expects to see.
  assign load_data = accept ? bus.s_in : acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= ACC_INIT;
      count    <= '0;
      nan_seen <= 1'b0;
      inf_seen <= 1'b0;
    end else begin
      if (bus.clear || (load && DRAIN_CLEARS)) begin
        acc   <= ACC_INIT;
        count <= '0;
      end else if (accept) begin
        acc <= bus.s_in;
        if (count != '1) count <= count + 1'b1;
      end
      // Flags survive a drain snapshot; only an explicit clear resets them.
      if (bus.clear) begin
        nan_seen <= 1'b0;
        inf_seen <= 1'b0;
      end else if (accept) begin
        nan_seen <= nan_seen | fp16_is_nan(bus.s_in);
        inf_seen <= inf_seen | fp16_is_inf(bus.s_in);
      end
    end
  end

  fma_drain_ser u_ser (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .load_data  (load_data),
    .byte_out   (bus.byte_out),
    .byte_valid (bus.byte_valid),
    .byte_ready (bus.byte_ready),
    .busy       (busy)
  );

  assign bus.acc_out  = acc;
  assign bus.count    = count;
  assign bus.nan_seen = nan_seen;
  assign bus.inf_seen = inf_seen;
  assign bus.busy     = busy;
endmodule

// File: tb/tb_fma_accum_drain.sv
// Directed then random stimulus against a queue-based behavioural model;
// a second instance with a 2-bit counter exercises saturation.
module tb_fma_accum_drain;
  import fp_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] s_in = '0;
  logic        s_save = 1'b0, clear = 1'b0, drain_req = 1'b0, byte_ready = 1'b0;

  fma_accum_drain_if #(.COUNT_W(8)) bus  ();
  fma_accum_drain_if #(.COUNT_W(2)) bus2 ();

  assign bus.s_in = s_in;        assign bus2.s_in = s_in;
  assign bus.s_save = s_save;    assign bus2.s_save = s_save;
  assign bus.clear = clear;      assign bus2.clear = clear;
  assign bus.drain_req = drain_req;   assign bus2.drain_req = drain_req;
  assign bus.byte_ready = byte_ready; assign bus2.byte_ready = byte_ready;

  fma_accum_drain #(.ACC_INIT(16'h0000), .COUNT_W(8), .DRAIN_CLEARS(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave));
  fma_accum_drain #(.ACC_INIT(16'h0000), .COUNT_W(2), .DRAIN_CLEARS(1'b1)) u_sat (
    .clk(clk), .rst_n(rst_n), .bus(bus2.slave));

  int tests = 0;
  int fails = 0;

  // Reference state: a plain value, an unbounded count, and a queue of bytes still owed.
  logic [15:0] m_acc;
  int          m_cnt;
  bit          m_nan, m_inf;
  logic [7:0]  m_q[$];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic model_reset();
    m_acc = 16'h0000; m_cnt = 0; m_nan = 0; m_inf = 0;
    m_q.delete();
  endtask

  task automatic check_all();
    chk("acc_out", bus.acc_out, m_acc);
    chk("count", {8'h00, bus.count}, 16'(sat(m_cnt, 255)));
    chk("count_sat2", {14'h0, bus2.count}, 16'(sat(m_cnt, 3)));
    chk("nan_seen", {15'h0, bus.nan_seen}, {15'h0, m_nan});
    chk("inf_seen", {15'h0, bus.inf_seen}, {15'h0, m_inf});
    chk("busy", {15'h0, bus.busy}, {15'h0, m_q.size() != 0});
    chk("byte_valid", {15'h0, bus.byte_valid}, {15'h0, m_q.size() != 0});
    if (m_q.size() != 0) chk("byte_out", {8'h00, bus.byte_out}, {8'h00, m_q[0]});
  endtask

  // One clock: model consumes the inputs present at the edge, then DUT is sampled 1ns later.
  task automatic tick();
    bit          was_busy, acc_ok, take;
    logic [15:0] snap;
    int          ex, man;
    was_busy = (m_q.size() != 0);
    acc_ok   = s_save && !clear;
    take     = drain_req && !was_busy;
    snap     = acc_ok ? s_in : m_acc;
    ex  = (int'(s_in) / 1024) % 32;
    man = int'(s_in) % 1024;
    if (was_busy && byte_ready) void'(m_q.pop_front());
    if (take) begin
      m_q.push_back(snap[15:8]);
      m_q.push_back(snap[7:0]);
    end
    if (clear || take) begin
      m_acc = 16'h0000; m_cnt = 0;
    end else if (acc_ok) begin
      m_acc = s_in; m_cnt++;
    end
    if (clear) begin
      m_nan = 0; m_inf = 0;
    end else if (acc_ok) begin
      if (ex == 31 && man != 0) m_nan = 1;
      if (ex == 31 && man == 0) m_inf = 1;
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    chk("rst_acc", bus.acc_out, 16'h0000);
    chk("rst_valid", {15'h0, bus.byte_valid}, 16'h0);
    rst_n = 1'b1;

    // accumulate two results, then an ignored non-save cycle
    s_save = 1; s_in = 16'h3C00; tick();
    chk("acc_3c00", bus.acc_out, 16'h3C00);
    s_in = 16'h4000; tick();
    chk("acc_4000", bus.acc_out, 16'h4000);
    chk("count_2", {8'h0, bus.count}, 16'd2);
    s_save = 0; s_in = 16'hFFFF; tick();
    chk("ignore_ffff", bus.acc_out, 16'h4000);

    // sticky flags and clear-over-save
    s_save = 1; s_in = 16'h7E01; tick();
    chk("nan_set", {15'h0, bus.nan_seen}, 16'h1);
    s_in = 16'hFC00; tick();
    chk("inf_set", {15'h0, bus.inf_seen}, 16'h1);
    clear = 1; s_in = 16'h4400; tick();
    chk("clr_acc", bus.acc_out, 16'h0000);
    chk("clr_flags", {14'h0, bus.nan_seen, bus.inf_seen}, 16'h0);
    clear = 0;

    // basic drain of 4248
    s_in = 16'h4248; tick();
    s_save = 0; drain_req = 1; byte_ready = 1; tick();
    chk("drain_hi", {8'h0, bus.byte_out}, 16'h0042);
    chk("drain_clears", bus.acc_out, 16'h0000);
    drain_req = 0; tick();
    chk("drain_lo", {8'h0, bus.byte_out}, 16'h0048);
    tick();
    chk("drain_done", {15'h0, bus.busy}, 16'h0);

    // bypass snapshot, backpressure, ignored second request
    s_save = 1; s_in = 16'h5000; drain_req = 1; byte_ready = 0; tick();
    s_save = 0;
    repeat (5) begin
      tick();
      chk("hold_hi", {7'h0, bus.byte_valid, bus.byte_out}, 16'h0150);
    end
    drain_req = 0; byte_ready = 1; tick();
    chk("bypass_lo", {8'h0, bus.byte_out}, 16'h0000);
    tick();

    // saturation on the 2-bit instance
    s_save = 1;
    for (int i = 0; i < 5; i++) begin
      s_in = 16'(16'h3800 + i); tick();
    end
    chk("sat_3", {14'h0, bus2.count}, 16'd3);
    s_save = 0;

    // asynchronous reset in the middle of HI
    drain_req = 1; byte_ready = 0; tick();
    drain_req = 0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_valid", {15'h0, bus.byte_valid}, 16'h0);
    chk("async_busy", {15'h0, bus.busy}, 16'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    check_all();

    // random traffic
    for (int n = 0; n < 600; n++) begin
      s_save     = ($urandom_range(0, 99) < 60);
      clear      = ($urandom_range(0, 99) < 4);
      drain_req  = ($urandom_range(0, 99) < 25);
      byte_ready = ($urandom_range(0, 99) < 65);
      case ($urandom_range(0, 9))
        0: s_in = FP16_QNAN;
        1: s_in = FP16_PINF;
        2: s_in = 16'hFC00;
        3: s_in = 16'h7D55;
        default: s_in = 16'($urandom);
      endcase
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fma_accum_drain.md
Name: fma_accum_drain

Overview:
- Downstream neighbour of the final FMA pipe stage, which produces the fp16 sum S and its save flag.
- Holds the fp16 running accumulator and presents it back to the first pipe stage as the C operand.
- Tracks NaN/Inf events and a result count.
- On request, snapshots the accumulator and drains it as two bytes over an 8-bit valid/ready port, so results can leave the chip through the narrow I/O.

Parameters:
- ACC_INIT, 16'h0000, accumulator value after reset and after clear (fp16 +0).
- COUNT_W, 8, width of the saturating accepted-result counter.
- DRAIN_CLEARS, 1, if 1 the accumulator resets to ACC_INIT when a drain snapshot is taken.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- s_in  in  16  fp16 result from the last pipe stage.
- s_save  in  1  s_in is valid this cycle.
- clear  in  1  synchronous accumulator/flag/count clear.
- acc_out  out  16  registered accumulator, drives C of the first pipe stage.
- drain_req  in  1  request snapshot and serial drain.
- byte_out  out  8  drained byte.
- byte_valid  out  1  byte_out valid.
- byte_ready  in  1  consumer accepts byte_out.
- busy  out  1  drain in progress (state != IDLE).
- nan_seen  out  1  sticky: an accepted s_in was NaN.
- inf_seen  out  1  sticky: an accepted s_in was ±Inf.
- count  out  COUNT_W  accepted results since last clear, saturating.

Behaviour:
- Reset (rst_n low, asynchronous): acc=ACC_INIT, state IDLE, byte_out=0, byte_valid=0, busy=0, nan_seen=0, inf_seen=0, count=0. Deassertion is seen at the next clk edge.
- Accept:
  - When s_save=1 and clear=0: acc<=s_in and count<=count+1, saturating at 2^COUNT_W-1.
  - nan_seen|= (s_in[14:10]==5'h1F && s_in[9:0]!=0).
  - inf_seen|= (s_in[14:10]==5'h1F && s_in[9:0]==0).
  - s_in is accepted unmodified; no re-rounding.
  - When s_save=0, s_in is ignored regardless of its value.
- acc_out = acc, registered: one cycle latency from s_save to acc_out.
- Clear: acc<=ACC_INIT, count<=0, nan_seen<=0, inf_seen<=0. Clear wins over s_save in the same cycle; that result is discarded and not counted.
- Drain FSM:
  - IDLE to HI on drain_req=1:
    - Snapshot register snap<=(s_save&&!clear) ? s_in : acc, which bypasses a same-cycle result.
    - If DRAIN_CLEARS=1, acc<=ACC_INIT and count<=0 in that cycle, overriding accept. The flags are not cleared.
  - HI: byte_valid=1, byte_out=snap[15:8]. On byte_ready=1 go to LO.
  - LO: byte_valid=1, byte_out=snap[7:0]. On byte_ready=1 go to IDLE.
  - byte_valid is asserted the cycle after drain_req is accepted.
  - byte_out/byte_valid are registered and held stable while valid and not ready.
  - drain_req is ignored while busy.
  - The accumulator continues to accept results while busy; snap is unaffected.
  - A drain_req in the same cycle the FSM returns LO to IDLE is ignored. It is accepted the next cycle if still high.
  - clear while busy affects only acc/count/flags; the drain completes.
- Reset mid-drain aborts the FSM to IDLE with byte_valid=0 immediately (asynchronous).
- Max throughput: one 16-bit drain per 3 cycles (IDLE, HI, LO) with byte_ready held high.

Decomposition:
- Shared package fp_pkg:
  - FP16 field constants: EXP_MSB=14, EXP_LSB=10, MAN_W=10, EXP_ALL1=5'h1F.
  - Canonical FP16_QNAN=16'h7FFF, FP16_PINF=16'h7C00, FP16_ZERO=16'h0000.
  - Drain state enum {IDLE,HI,LO}.
- Sub-module fma_drain_ser:
  - Owns the snap register, the FSM and the byte handshake.
  - Interface: load, load_data[15:0], byte_out, byte_valid, byte_ready, busy.
- The top level holds acc, count, flags and the snapshot mux.

Test Plan:
- Reset then idle: acc_out=16'h0000, count=0, byte_valid=0, busy=0. With rst_n pulsed low mid-HI, byte_valid drops without a clock.
- s_save with s_in=16'h3C00, then 16'h4000: acc_out=3C00 one cycle after the first and 4000 after the second; count=2. With s_save=0 and s_in=16'hFFFF, acc_out is unchanged.
- s_in=16'h7E01 accepted: nan_seen=1. s_in=16'hFC00: inf_seen=1. clear together with s_save=16'h4400: acc_out=0000, count=0, flags=0.
- acc=16'h4248, drain_req with byte_ready=1:
  - Next two cycles byte_out=8'h42 then 8'h48, each with byte_valid=1.
  - busy is high for exactly 2 cycles.
  - With DRAIN_CLEARS=1, acc_out=0000 after the snapshot.
- drain_req in the same cycle as s_save s_in=16'h5000: drained bytes are 50,00. With byte_ready held low 5 cycles, byte_out stays 8'h50 and byte_valid stays 1. A second drain_req during busy is ignored.
- COUNT_W=2, 5 accepted results: count saturates at 3.
